// File: rtl/pipe_issue_ctrl_pkg.sv
// Shared definitions for the pipeline issue controller.
// Holds the ALU function codes, the per-function source-usage masks,
// field widths, the instruction record and the controller state encoding.
package pipe_issue_ctrl_pkg;

    localparam int REG_W  = 4;
    localparam int ADDR_W = 8;
    localparam int FUNC_W = 4;

    typedef enum logic [FUNC_W-1:0] {
        FUNC_ADD  = 4'd0,   // A,B
        FUNC_SUB  = 4'd1,   // A,B
        FUNC_AND  = 4'd2,   // A,B
        FUNC_NEG  = 4'd3,   // A
        FUNC_MOVB = 4'd4,   // B
        FUNC_OR   = 4'd5,   // A,B
        FUNC_XOR  = 4'd6,   // A,B
        FUNC_SLT  = 4'd7,   // A,B
        FUNC_INC  = 4'd8,   // A
        FUNC_NOTB = 4'd9,   // B
        FUNC_DEC  = 4'd10,  // A
        FUNC_SHL  = 4'd11   // A (shift by fixed amount)
    } func_e;

    localparam logic [FUNC_W-1:0] FUNC_LAST = FUNC_SHL;

    // Bit f set -> function code f reads that source register.
    localparam logic [15:0] USES_A = 16'h0DEF;  // 0,1,2,3,5,6,7,8,10,11
    localparam logic [15:0] USES_B = 16'h02F7;  // 0,1,2,4,5,6,7,9

    typedef enum logic {
        ST_RUN   = 1'b0,
        ST_DRAIN = 1'b1
    } state_e;

    typedef struct packed {
        logic [REG_W-1:0]  rs1;
        logic [REG_W-1:0]  rs2;
        logic [REG_W-1:0]  rd;
        logic [FUNC_W-1:0] func;
        logic [ADDR_W-1:0] addr;
    } instr_t;

    function automatic logic func_legal(input logic [FUNC_W-1:0] f);
        return f <= FUNC_LAST;
    endfunction

endpackage

// File: rtl/pipe_issue_ctrl_if.sv
// Instruction-in / issue-out bus of the issue controller.
//   in_*  : upstream valid/ready handshake carrying one instruction
//   iss_* : registered 1-cycle issue strobe plus fields to pipeline stage 1
// master : the upstream/pipeline side (drives in_*, observes in_ready, iss_*)
// slave  : the controller (accepts in_*, drives in_ready and iss_*)
interface pipe_issue_ctrl_if;
    import pipe_issue_ctrl_pkg::*;

    logic              in_valid;
    logic              in_ready;
    logic [REG_W-1:0]  in_rs1;
    logic [REG_W-1:0]  in_rs2;
    logic [REG_W-1:0]  in_rd;
    logic [FUNC_W-1:0] in_func;
    logic [ADDR_W-1:0] in_addr;

    logic              iss_valid;
    logic [REG_W-1:0]  iss_rs1;
    logic [REG_W-1:0]  iss_rs2;
    logic [REG_W-1:0]  iss_rd;
    logic [FUNC_W-1:0] iss_func;
    logic [ADDR_W-1:0] iss_addr;

    modport master (
        output in_valid, in_rs1, in_rs2, in_rd, in_func, in_addr,
        input  in_ready,
        input  iss_valid, iss_rs1, iss_rs2, iss_rd, iss_func, iss_addr
    );

    modport slave (
        input  in_valid, in_rs1, in_rs2, in_rd, in_func, in_addr,
        output in_ready,
        output iss_valid, iss_rs1, iss_rs2, iss_rd, iss_func, iss_addr
    );

endinterface

// File: rtl/pipe_issue_ctrl_scoreboard.sv
// In-flight destination tracker for the issue controller.
// A WB_LAT-deep shift register of {valid, rd}; an issued rd enters slot 0
// and falls off the end WB_LAT edges later, when its regbank write is
// visible to stage 1.
// Ports: clk, rst (async, high); push/push_rd (issue of rd this edge);
//        rs1/rs2 queries -> hit1/hit2 (pending write matches); empty.
module pipe_scoreboard
    import pipe_issue_ctrl_pkg::*;
#(
    parameter int WB_LAT = 3
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [REG_W-1:0] push_rd,
    input  logic [REG_W-1:0] rs1,
    input  logic [REG_W-1:0] rs2,
    output logic             hit1,
    output logic             hit2,
    output logic             empty
);

    logic [WB_LAT-1:0]            sb_v;
    logic [WB_LAT-1:0][REG_W-1:0] sb_rd;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sb_v  <= '0;
            sb_rd <= '0;
        end else begin
            sb_v[0] <= push;
            if (push)
                sb_rd[0] <= push_rd;
            for (int i = 1; i < WB_LAT; i++) begin
                sb_v[i]  <= sb_v[i-1];
                sb_rd[i] <= sb_rd[i-1];
            end
        end
    end

    always_comb begin
        hit1 = 1'b0;
        hit2 = 1'b0;
        for (int i = 0; i < WB_LAT; i++) begin
            if (sb_v[i] && sb_rd[i] == rs1) hit1 = 1'b1;
            if (sb_v[i] && sb_rd[i] == rs2) hit2 = 1'b1;
        end
    end

    assign empty = ~|sb_v;

endmodule

// File: rtl/pipe_issue_ctrl.sv
// Issue controller feeding the 4-stage regbank/ALU/mem pipeline.
// One-entry hold register takes instructions over a valid/ready handshake,
// waits out read-after-write hazards against the in-flight scoreboard, then
// issues at most one instruction per cycle. Illegal func codes are dropped
// with a pulse; a flush pulse drains everything and reports completion.
// Ports: clk, rst (async, high)
//        bus        : slave side of pipe_issue_ctrl_if (in_* handshake, iss_*)
//        flush      : drain request pulse
//        illegal    : 1-cycle pulse, held instruction dropped (func 12..15)
//        flush_done : 1-cycle pulse, drain complete
//        busy       : hold register or scoreboard occupied
//        stall_cnt  : saturating count of hazard-stall cycles
module pipe_issue_ctrl
    import pipe_issue_ctrl_pkg::*;
#(
    parameter int WB_LAT = 3,
    parameter int CNT_W  = 16
) (
    input  logic             clk,
    input  logic             rst,
    pipe_issue_ctrl_if.slave bus,
    input  logic             flush,
    output logic             illegal,
    output logic             flush_done,
    output logic             busy,
    output logic [CNT_W-1:0] stall_cnt
);

    state_e state, state_nx;
    logic   flush_done_nx;

    logic   hold_v;
    instr_t hold;
    instr_t iss_q;
    logic   iss_v;

    logic   legal, uses_a, uses_b;
    logic   hit1, hit2, sb_empty;
    logic   hazard, issue, drop, accept;

    assign legal  = func_legal(hold.func);
    assign uses_a = USES_A[hold.func];
    assign uses_b = USES_B[hold.func];

    // A source the function does not read is never checked.
    assign hazard = hold_v & legal & ((uses_a & hit1) | (uses_b & hit2));
    assign issue  = hold_v & legal & ~hazard;
    assign drop   = hold_v & ~legal;

    // Hold may refill on the same edge it empties, giving 1/cycle throughput.
    assign bus.in_ready = ~rst & (state == ST_RUN) & (~hold_v | issue | drop);
    assign accept       = bus.in_valid & bus.in_ready;

    assign busy = hold_v | ~sb_empty;

    pipe_scoreboard #(.WB_LAT(WB_LAT)) u_sb (
        .clk     (clk),
        .rst     (rst),
        .push    (issue),
        .push_rd (hold.rd),
        .rs1     (hold.rs1),
        .rs2     (hold.rs2),
        .hit1    (hit1),
        .hit2    (hit2),
        .empty   (sb_empty)
    );

    // State machine: RUN <-> DRAIN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= ST_RUN;
            flush_done <= 1'b0;
        end else begin
            state      <= state_nx;
            flush_done <= flush_done_nx;
        end
    end

    always_comb begin
        state_nx      = state;
        flush_done_nx = 1'b0;
        case (state)
            ST_RUN: begin
                if (flush)
                    state_nx = ST_DRAIN;
            end
            ST_DRAIN: begin
                // in_ready is low here, so once hold and scoreboard are both
                // empty nothing else can be in flight.
                if (!hold_v && sb_empty) begin
                    flush_done_nx = 1'b1;
                    state_nx      = ST_RUN;
                end
            end
            default: state_nx = ST_RUN;
        endcase
    end

    // Hold register, issue register, illegal pulse, stall counter
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hold_v    <= 1'b0;
            hold      <= '0;
            iss_v     <= 1'b0;
            iss_q     <= '0;
            illegal   <= 1'b0;
            stall_cnt <= '0;
        end else begin
            if (accept) begin
                hold_v <= 1'b1;
                hold   <= '{rs1:  bus.in_rs1,  rs2:  bus.in_rs2, rd: bus.in_rd,
                            func: bus.in_func, addr: bus.in_addr};
            end else if (issue || drop) begin
                hold_v <= 1'b0;
            end

            iss_v <= issue;
            if (issue)
                iss_q <= hold;

            illegal <= drop;

            if (hazard && stall_cnt != {CNT_W{1'b1}})
                stall_cnt <= stall_cnt + 1'b1;
        end
    end

    assign bus.iss_valid = iss_v;
    assign bus.iss_rs1   = iss_q.rs1;
    assign bus.iss_rs2   = iss_q.rs2;
    assign bus.iss_rd    = iss_q.rd;
    assign bus.iss_func  = iss_q.func;
    assign bus.iss_addr  = iss_q.addr;

endmodule
